// File: rtl/fifo_if.sv
// Handshake and status bundle between FIFO users and the sync_fifo_core storage end.
// overflow/underflow exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface fifo_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    // Producers and consumers together form the master side.
    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, count, wr_ptr, rd_ptr
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , input overflow, underflow
`endif
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, count, wr_ptr, rd_ptr
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , output overflow, underflow
`endif
    );
endinterface

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO storage/pointer core, depth 2**ADDR_WIDTH, one-cycle registered read.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_core #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input logic   clk,
    input logic   rst,
    fifo_if.slave bus
);
    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_nxt;
    logic                  full_q, empty_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  wr_acc, rd_acc;

    // Acceptance uses only registered flags; reset suppresses both sides.
    assign wr_acc = bus.wr_en && !full_q  && !rst;
    assign rd_acc = bus.rd_en && !empty_q && !rst;

    always_comb begin
        count_nxt = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + CNT_ONE;
            2'b01:   count_nxt = count_q - CNT_ONE;
            default: count_nxt = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_acc) begin
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                rd_data_q <= mem[rd_ptr_q];
            end
            rd_valid_q <= rd_acc;
            count_q    <= count_nxt;
            full_q     <= (count_nxt == CNT_FULL);
            empty_q    <= (count_nxt == '0);
        end
    end

    // NOTE: storage has no reset; count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= bus.wr_data;
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en && full_q)  overflow_q  <= 1'b1;
            if (bus.rd_en && empty_q) underflow_q <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.wr_ptr   = wr_ptr_q;
    assign bus.rd_ptr   = rd_ptr_q;
endmodule

// File: tb/tb_sync_fifo_core.sv
// Directed bench for sync_fifo_core (ADDR_WIDTH=2): fill, drain, simultaneous access, boundaries, reset.
// Flag checks are included when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_core;
    localparam int AW = 2;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    fifo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sync_fifo_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 ns later, and check the structural invariants.
    task automatic cycle();
        logic [AW:0] ptr_diff;
        @(posedge clk);
        #1;
        ptr_diff = {1'b0, AW'(bus.wr_ptr - bus.rd_ptr)};
        check("inv_not_full_and_empty", {31'd0, bus.full && bus.empty}, 32'd0);
        check("inv_count_vs_ptrs", {29'd0, bus.count}, bus.full ? 32'd4 : {29'd0, ptr_diff});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"},    {31'd0, bus.empty},    32'd1);
        check({tag, "_full"},     {31'd0, bus.full},     32'd0);
        check({tag, "_count"},    {29'd0, bus.count},    32'd0);
        check({tag, "_wr_ptr"},   {30'd0, bus.wr_ptr},   32'd0);
        check({tag, "_rd_ptr"},   {30'd0, bus.rd_ptr},   32'd0);
        check({tag, "_rd_data"},  {24'd0, bus.rd_data},  32'd0);
        check({tag, "_rd_valid"}, {31'd0, bus.rd_valid}, 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check({tag, "_overflow"},  {31'd0, bus.overflow},  32'd0);
        check({tag, "_underflow"}, {31'd0, bus.underflow}, 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.rd_en = 1'b0;

        // Reset then idle
        cycle();
        cycle();
        rst = 1'b0;
        check_reset_state("reset");
        cycle();
        check_reset_state("idle");

        // Fill with A0..A3
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'hA0 + 8'(i);
            cycle();
            check("fill_count", {29'd0, bus.count}, 32'(i + 1));
        end
        check("fill_full",   {31'd0, bus.full},   32'd1);
        check("fill_empty",  {31'd0, bus.empty},  32'd0);
        check("fill_wr_ptr", {30'd0, bus.wr_ptr}, 32'd0);

        // Write while full is dropped
        bus.wr_data = 8'hFF;
        cycle();
        check("ovf_wr_ptr", {30'd0, bus.wr_ptr}, 32'd0);
        check("ovf_count",  {29'd0, bus.count},  32'd4);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("ovf_flag", {31'd0, bus.overflow}, 32'd1);
`endif
        bus.wr_en = 1'b0;

        // Drain: data appears the edge after rd_en, in order
        for (int i = 0; i < 4; i++) begin
            bus.rd_en = 1'b1;
            cycle();
            check("drain_rd_data",  {24'd0, bus.rd_data},  32'hA0 + 32'(i));
            check("drain_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
        end
        check("drain_empty",  {31'd0, bus.empty},  32'd1);
        check("drain_count",  {29'd0, bus.count},  32'd0);
        check("drain_rd_ptr", {30'd0, bus.rd_ptr}, 32'd0);

        // Read while empty is dropped; rd_data holds
        cycle();
        check("udf_rd_ptr",   {30'd0, bus.rd_ptr},   32'd0);
        check("udf_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("udf_rd_data",  {24'd0, bus.rd_data},  32'hA3);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("udf_flag", {31'd0, bus.underflow}, 32'd1);
`endif
        bus.rd_en = 1'b0;

        // Preload B0,B1 then six simultaneous cycles at count=2
        for (int i = 0; i < 2; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'hB0 + 8'(i);
            cycle();
        end
        check("sim_pre_count", {29'd0, bus.count}, 32'd2);
        for (int i = 0; i < 6; i++) begin
            bus.wr_en = 1'b1;
            bus.rd_en = 1'b1;
            bus.wr_data = 8'hB2 + 8'(i);
            cycle();
            check("sim_rd_data",  {24'd0, bus.rd_data},  32'hB0 + 32'(i));
            check("sim_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
            check("sim_count",    {29'd0, bus.count},    32'd2);
        end
        check("sim_wr_ptr", {30'd0, bus.wr_ptr}, 32'd0);
        check("sim_rd_ptr", {30'd0, bus.rd_ptr}, 32'd2);

        // Top up to full (B6,B7,C0,C1), then both asserted: only the read goes
        bus.rd_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'hC0 + 8'(i);
            cycle();
        end
        check("bfull_full",   {31'd0, bus.full},   32'd1);
        check("bfull_wr_ptr", {30'd0, bus.wr_ptr}, 32'd2);
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.wr_data = 8'hEE;
        cycle();
        check("bfull_count",   {29'd0, bus.count},    32'd3);
        check("bfull_full2",   {31'd0, bus.full},     32'd0);
        check("bfull_wr_ptr2", {30'd0, bus.wr_ptr},   32'd2);
        check("bfull_rd_ptr",  {30'd0, bus.rd_ptr},   32'd3);
        check("bfull_rd_data", {24'd0, bus.rd_data},  32'hB6);
        check("bfull_rd_vld",  {31'd0, bus.rd_valid}, 32'd1);

        // Reset at count=3 with both requests asserted
        rst = 1'b1;
        bus.wr_data = 8'h77;
        cycle();
        rst = 1'b0;
        check_reset_state("midrst");

        // At empty with both asserted: only the write goes, to address 0
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.wr_data = 8'hD5;
        cycle();
        check("bempty_count",    {29'd0, bus.count},    32'd1);
        check("bempty_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("bempty_wr_ptr",   {30'd0, bus.wr_ptr},   32'd1);
        check("bempty_rd_ptr",   {30'd0, bus.rd_ptr},   32'd0);
        check("bempty_rd_data",  {24'd0, bus.rd_data},  32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("bempty_underflow", {31'd0, bus.underflow}, 32'd1);
        check("bempty_overflow",  {31'd0, bus.overflow},  32'd0);
`endif
        bus.wr_en = 1'b0;
        cycle();
        check("addr0_rd_data",  {24'd0, bus.rd_data},  32'hD5);
        check("addr0_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
        check("addr0_empty",    {31'd0, bus.empty},    32'd1);
        bus.rd_en = 1'b0;
        cycle();
        check("idle_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("idle_rd_data",  {24'd0, bus.rd_data},  32'hD5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
- Single-clock synchronous FIFO: the storage/pointer end of the fifo_if handshake.
- Producers drive wr_en/wr_data; consumers drive rd_en and take rd_data.
- Exports full, empty, wr_ptr, rd_ptr and count so interface-level checkers can monitor pointer behaviour directly.
- Depth = 2**ADDR_WIDTH entries.

Parameters:
- ADDR_WIDTH, 2, pointer/address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, width of each stored word.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write data, sampled when a write is accepted.
- rd_en  input  1  read request.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  high for one cycle when rd_data holds newly read data.
- full  output  1  FIFO holds 2**ADDR_WIDTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  ADDR_WIDTH+1  current occupancy.
- wr_ptr  output  ADDR_WIDTH  next write address.
- rd_ptr  output  ADDR_WIDTH  next read address.

Behaviour:
- Reset, sampled at a clock edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_data=0, rd_valid=0. Memory contents are not reset. Reset overrides any concurrent wr_en/rd_en; there is no partial update.
- Accepted write: wr_acc = wr_en && !full. Store wr_data at mem[wr_ptr]; wr_ptr increments modulo 2**ADDR_WIDTH.
- Accepted read: rd_acc = rd_en && !empty. rd_data <= mem[rd_ptr] on the same edge; rd_ptr increments modulo 2**ADDR_WIDTH; rd_valid=1 in the following cycle.
  - Read latency is 1 cycle.
  - rd_data holds its value when no read is accepted.
- Full/empty decisions use the registered flags from the start of the cycle, never same-cycle combinational bypass.
- Write when full: rejected; wr_ptr, count and memory unchanged. This applies even if a read is accepted in the same cycle.
- Read when empty: rejected; rd_ptr, count and rd_data unchanged; rd_valid=0. This applies even if a write is accepted in the same cycle, so there is no fall-through.
- Both accepted in one cycle: both pointers advance, count unchanged, full/empty unchanged.
- count: +1 on write-only, -1 on read-only, else hold.
- Flag update: empty = (next count == 0), full = (next count == 2**ADDR_WIDTH), both registered.
- Pointer wrap: 2**ADDR_WIDTH-1 -> 0. Full vs empty is disambiguated by count, not by pointer equality.
- Read-during-write to the same address cannot occur in one cycle: equal pointers imply full or empty, and either condition blocks one side.
- Invariants (checked by bench):
  - full and empty never both 1.
  - count == (wr_ptr - rd_ptr) mod depth, except count == depth when full.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- When defined, adds outputs overflow (1) and underflow (1), both sticky:
  - overflow sets on wr_en && full.
  - underflow sets on rd_en && empty.
  - Both clear only on rst; reset value 0.
- When undefined, the ports are absent and rejected requests are silently dropped.
- Core datapath and timing are identical either way.

Test Plan:
- Reset then idle: after rst=1 for 2 cycles -> empty=1, full=0, count=0, wr_ptr=0, rd_ptr=0, rd_data=0, rd_valid=0.
- Fill (ADDR_WIDTH=2): write 0xA0..0xA3 on 4 consecutive cycles -> count=4, full=1, wr_ptr wrapped to 0.
  - A 5th write of 0xFF -> wr_ptr stays 0, count stays 4.
  - With SYNC_FIFO_ERR_FLAGS_EN, overflow=1.
- Drain: 4 consecutive reads after the fill -> rd_data 0xA0, 0xA1, 0xA2, 0xA3, each one cycle after its rd_en with rd_valid=1; then empty=1.
  - A further rd_en -> rd_ptr stable, rd_valid=0, rd_data holds 0xA3; underflow=1 if macro is defined.
- Simultaneous access at count=2: wr_en=rd_en=1 for 6 cycles -> count stays 2; both pointers advance 6 (mod 4, net +2); data order preserved.
- Boundary simultaneous access:
  - At full with wr_en=rd_en=1 -> only the read is accepted; count=3, full=0, wr_ptr stable.
  - At empty with both asserted -> only the write is accepted; count=1, rd_valid=0 next cycle.
- Reset mid-operation: at count=3, assert rst together with wr_en=rd_en=1 -> next cycle all outputs at reset values; the first write after reset lands at address 0.
